yolo_osif_writer: RTL and testbench

Result-drain engine on the core side of the output stream path. On `start` it reads `beat_cnt` consecutive 64-bit words from an on-chip result memory (1-cycle read latency), then pushes them into the output-stream FIFO write interface (`osif_*`). The first beat is tagged with `user`, the final beat with `last`. The block absorbs `osif_full_n` backpressure without losing memory read data, and it sustains one beat per cycle when the FIFO is not full.

---
 rtl/yolo_pkg.sv | 14 +
 rtl/yolo_skid_fifo2.sv | 47 ++++
 rtl/yolo_osif_writer.sv | 115 +++++++++++
 tb/tb_yolo_osif_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/yolo_pkg.sv
// Shared defaults and FSM state type for the yolo output-stream drain path.
package yolo_pkg;

   localparam int DEF_TBITS = 64;
   localparam int DEF_TBYTE = DEF_TBITS / 8;
   localparam int DEF_AW    = 13;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/yolo_skid_fifo2.sv
// Two-entry registered FIFO catching memory read data so backpressure never drops a beat.
module yolo_skid_fifo2 #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic [1:0]   count,
   output logic         empty_n
);

   logic [W-1:0] r_data [2];
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data[0] <= '0;
         r_data[1] <= '0;
         r_wr_ptr  <= 1'b0;
         r_rd_ptr  <= 1'b0;
         r_count   <= 2'd0;
      end else begin
         if (push) begin
            r_data[r_wr_ptr] <= din;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({push, pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign dout    = r_data[r_rd_ptr];
   assign count   = r_count;
   assign empty_n = (r_count != 2'd0);

endmodule

// File: rtl/yolo_osif_writer.sv
// Drains beat_cnt words from result memory into the output-stream FIFO,
// tagging first beat with user and final beat with last.
module yolo_osif_writer
   import yolo_pkg::*;
#(
   parameter int TBITS = DEF_TBITS,
   parameter int TBYTE = DEF_TBYTE,
   parameter int AW    = DEF_AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AW-1:0]    base_addr,
   input  logic [AW:0]      beat_cnt,
   output logic             busy,
   output logic             done,
   output logic [AW-1:0]    mem_addr,
   output logic             mem_en,
   input  logic [TBITS-1:0] mem_dout,
   output logic [TBITS-1:0] osif_data_din,
   output logic [TBYTE-1:0] osif_strb_din,
   output logic             osif_last_din,
   output logic             osif_user_din,
   input  logic             osif_full_n,
   output logic             osif_write
);

   state_t           r_state;
   state_t           w_state_next;
   logic [AW-1:0]    r_base;
   logic [AW:0]      r_cnt;
   logic [AW:0]      r_rd_idx;
   logic [AW:0]      r_wr_idx;
   logic             r_inflight;
   logic             r_busy;
   logic             r_done;

   logic             w_start_ok;
   logic             w_pop;
   logic             w_empty_n;
   logic [1:0]       w_count;
   logic [2:0]       w_occ;
   logic             w_mem_en;
   logic             w_last_beat;
   logic [TBITS-1:0] w_head;

   yolo_skid_fifo2 #(.W(TBITS)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .push    (r_inflight),
      .din     (mem_dout),
      .pop     (w_pop),
      .dout    (w_head),
      .count   (w_count),
      .empty_n (w_empty_n)
   );

   assign w_start_ok  = (r_state == IDLE) && start;
   assign w_pop       = w_empty_n && osif_full_n;
   // Reads in flight will land in the buffer, so they count as occupied slots.
   assign w_occ       = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_mem_en    = (r_state == RUN) && (r_rd_idx < r_cnt) && (w_occ < 3'd2);
   assign w_last_beat = (r_wr_idx == (r_cnt - {{AW{1'b0}}, 1'b1}));

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: if (start) w_state_next = (beat_cnt == '0) ? DONE : RUN;
         RUN:  if (w_pop && w_last_beat) w_state_next = DONE;
         DONE: w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_base     <= '0;
         r_cnt      <= '0;
         r_rd_idx   <= '0;
         r_wr_idx   <= '0;
         r_inflight <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_inflight <= w_mem_en;
         r_busy     <= (w_state_next == RUN);
         r_done     <= (w_state_next == DONE);
         if (w_start_ok) begin
            r_base   <= base_addr;
            r_cnt    <= beat_cnt;
            r_rd_idx <= '0;
            r_wr_idx <= '0;
         end else begin
            if (w_mem_en) r_rd_idx <= r_rd_idx + 1'b1;
            if (w_pop)    r_wr_idx <= r_wr_idx + 1'b1;
         end
      end
   end

   assign busy          = r_busy;
   assign done          = r_done;
   assign mem_en        = w_mem_en;
   assign mem_addr      = r_base + r_rd_idx[AW-1:0];
   assign osif_write    = w_pop;
   assign osif_data_din = w_pop ? w_head : '0;
   assign osif_strb_din = {TBYTE{w_pop}};
   assign osif_user_din = w_pop && (r_wr_idx == '0);
   assign osif_last_din = w_pop && w_last_beat;

endmodule

// File: tb/tb_yolo_osif_writer.sv
// Randomized scoreboard bench for yolo_osif_writer: expected beats queued at start, monitor pops on each write.
module tb_yolo_osif_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [12:0] base_addr;
   logic [13:0] beat_cnt;
   logic        busy, done, mem_en;
   logic [12:0] mem_addr;
   logic [63:0] mem_dout;
   logic [63:0] osif_data_din;
   logic [7:0]  osif_strb_din;
   logic        osif_last_din, osif_user_din, osif_full_n, osif_write;

   yolo_osif_writer dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .base_addr     (base_addr),
      .beat_cnt      (beat_cnt),
      .busy          (busy),
      .done          (done),
      .mem_addr      (mem_addr),
      .mem_en        (mem_en),
      .mem_dout      (mem_dout),
      .osif_data_din (osif_data_din),
      .osif_strb_din (osif_strb_din),
      .osif_last_din (osif_last_din),
      .osif_user_din (osif_user_din),
      .osif_full_n   (osif_full_n),
      .osif_write    (osif_write)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] data;
      logic        user;
      logic        last;
   } beat_t;

   logic [63:0] mem [8192];
   beat_t       exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          issued = 0;
   int          written = 0;
   int          total_writes = 0;
   int          fn_mode = 0;
   int          pidx = 0;
   logic [4:0]  pat = 5'b01001;   // full_n sequence 1,0,0,1,0 read from bit 0 upward

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Synchronous result memory with one-cycle latency; junk on idle cycles exposes timing errors.
   always @(posedge clk) begin
      if (mem_en) mem_dout <= mem[mem_addr];
      else        mem_dout <= {$urandom(), $urandom()};
   end

   initial begin
      osif_full_n = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (fn_mode)
            0: osif_full_n = 1'b1;
            1: begin
               osif_full_n = pat[pidx];
               pidx = (pidx + 1) % 5;
            end
            default: osif_full_n = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor / scoreboard
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (osif_write) begin
            written++;
            total_writes++;
            chk("write_while_full", 64'(osif_full_n), 64'd1);
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 64'(osif_write), 64'd0);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", osif_data_din, e.data);
               chk("beat_user", 64'(osif_user_din), 64'(e.user));
               chk("beat_last", 64'(osif_last_din), 64'(e.last));
               chk("beat_strb", 64'(osif_strb_din), 64'hFF);
            end
         end else begin
            chk("idle_strb", 64'(osif_strb_din), 64'd0);
            chk("idle_tags", 64'({osif_user_din, osif_last_din}), 64'd0);
         end
         if (mem_en) begin
            issued++;
            chk("outstanding_le2", 64'((issued - written) <= 2), 64'd1);
         end
         if (rst) begin
            issued  = 0;
            written = 0;
            exp_q.delete();
         end
      end
   end

   task automatic push_expect(input logic [12:0] b, input int n);
      beat_t e;
      for (int i = 0; i < n; i++) begin
         e.data = mem[13'(b + 13'(i))];
         e.user = (i == 0);
         e.last = (i == n - 1);
         exp_q.push_back(e);
      end
   endtask

   // mode 0: full_n held high with cycle-exact timing checks; 1: fixed pattern; 2: random.
   task automatic run_xfer(input logic [12:0] b, input int n, input int mode, input bit busy_start);
      int c = 0;
      int dones = 0;
      int done_c = 0;
      int limit;
      @(negedge clk);
      fn_mode = mode;
      pidx = 0;
      @(negedge clk);
      base_addr = b;
      beat_cnt  = 14'(n);
      start     = 1'b1;
      push_expect(b, n);
      $display("xfer base=0x%04h cnt=%0d mode=%0d busy_start=%0d", b, n, mode, busy_start);
      limit = (mode == 0) ? n + 8 : 40 * n + 60;
      while (c < limit) begin
         @(negedge clk);
         c++;
         if (c == 1) start = 1'b0;
         if (busy_start && c == 2) begin
            base_addr = b ^ 13'h0555;
            beat_cnt  = 14'(n + 3);
            start     = 1'b1;
         end
         if (busy_start && c == 3) start = 1'b0;
         if (done) begin
            dones++;
            if (done_c == 0) done_c = c;
         end
         if (mode == 0) begin
            chk("t_busy", 64'(busy), 64'(n > 0 && c <= n + 2));
            chk("t_done", 64'(done), 64'((n == 0) ? (c == 1) : (c == n + 3)));
            chk("t_mem_en", 64'(mem_en), 64'(n > 0 && c <= n));
            chk("t_write", 64'(osif_write), 64'(n > 0 && c >= 3 && c <= n + 2));
            if (n > 0 && c <= n) chk("t_mem_addr", 64'(mem_addr), 64'(13'(b + 13'(c - 1))));
         end
         if (done_c != 0 && c >= done_c + 2) break;
      end
      chk("done_pulses", 64'(dones), 64'd1);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int tw0;
      int k;
      rst = 1'b1;
      start = 1'b0;
      base_addr = '0;
      beat_cnt = '0;
      for (int a = 0; a < 8192; a++) mem[a] = 64'(a);
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_mem_en", 64'(mem_en), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_write", 64'(osif_write), 64'd0);
      chk("rst_data", osif_data_din, 64'd0);
      rst = 1'b0;

      run_xfer(13'h0010, 4, 0, 1'b0);
      for (int a = 0; a < 8192; a++) mem[a] = {$urandom(), $urandom()};
      run_xfer(13'h0020, 16, 1, 1'b0);
      run_xfer(13'h0100, 0, 0, 1'b0);
      run_xfer(13'h1FFE, 4, 0, 1'b0);
      run_xfer(13'h0300, 6, 0, 1'b1);

      // Reset in the middle of an 8-beat transfer
      @(negedge clk);
      fn_mode = 0;
      @(negedge clk);
      base_addr = 13'h0400;
      beat_cnt  = 14'd8;
      start     = 1'b1;
      push_expect(13'h0400, 8);
      $display("xfer base=0x0400 cnt=8 interrupted by reset");
      tw0 = total_writes;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while ((total_writes - tw0) < 3 && k < 100) begin
         @(posedge clk);
         #2;
         k++;
      end
      chk("reset_reach_3_beats", 64'((total_writes - tw0) >= 3), 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #2;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_done", 64'(done), 64'd0);
      chk("mid_rst_mem_en", 64'(mem_en), 64'd0);
      chk("mid_rst_write", 64'(osif_write), 64'd0);
      chk("mid_rst_tags", 64'({osif_user_din, osif_last_din}), 64'd0);
      chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("mid_rst_data", osif_data_din, 64'd0);
      chk("mid_rst_strb", 64'(osif_strb_din), 64'd0);
      rst = 1'b0;
      run_xfer(13'h0555, 2, 0, 1'b0);

      for (int t = 0; t < 10; t++) begin
         run_xfer(13'($urandom_range(0, 8191)), int'($urandom_range(0, 40)),
                  int'($urandom_range(0, 2)), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
